// File: rtl/dsp_goertzel_multibin.sv
`default_nettype none
// ============================================================================
// Module   : dsp_goertzel_multibin
// Purpose  : Time-multiplexed multi-bin Goertzel engine; one bin updated per
//            clock, bin-tagged magnitude stream at each frame end.
//            Optional macro GOERTZEL_DC_REMOVE_EN: treat samples as offset binary.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_goertzel_multibin #(
    parameter int D_W         = 8,
    parameter int N_BINS      = 4,
    parameter int BIN_BITS    = 2,
    parameter int NUM_SAMPLES = 512,
    parameter int NS_BITS     = 9,
    parameter int ACC_W       = 32,
    parameter int MAG_W       = 16,
    parameter int MAG_SHIFT   = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                enable,
    input  logic                smp_valid,
    input  logic [D_W-1:0]      smp_data,
    input  logic                coef_we,
    input  logic [BIN_BITS-1:0] coef_addr,
    input  logic [15:0]         coef_cos,
    input  logic [15:0]         coef_sin,
    output logic                mag_valid,
    output logic [MAG_W-1:0]    mag,
    output logic [BIN_BITS-1:0] mag_bin,
    output logic                frame_done,
    output logic                busy,
    output logic                overrun
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_UPDATE    = 3'd1;
    localparam logic [2:0] c_ST_FINAL_MUL = 3'd2;
    localparam logic [2:0] c_ST_FINAL_MAG = 3'd3;
    localparam logic [2:0] c_ST_DONE      = 3'd4;

    localparam logic [BIN_BITS-1:0] c_LAST_BIN  = BIN_BITS'(N_BINS - 1);
    localparam logic [BIN_BITS-1:0] c_BIN_ONE   = BIN_BITS'(1);
    localparam logic [NS_BITS:0]    c_CNT_ONE   = (NS_BITS + 1)'(1);
    localparam logic [NS_BITS:0]    c_FRAME_LEN = (NS_BITS + 1)'(NUM_SAMPLES);
    localparam logic [ACC_W:0]      c_ABS_ONE   = (ACC_W + 1)'(1);
    localparam logic [ACC_W+1:0]    c_MAG_MAX   = (ACC_W + 2)'({MAG_W{1'b1}});

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic                      w_busy;

    logic signed [15:0]        r_cos [N_BINS];
    logic signed [15:0]        r_sin [N_BINS];
    logic signed [ACC_W-1:0]   r_s1  [N_BINS];
    logic signed [ACC_W-1:0]   r_s2  [N_BINS];

    logic signed [ACC_W-1:0]   r_x;
    logic signed [ACC_W-1:0]   r_re;
    logic signed [ACC_W-1:0]   r_im;
    logic [BIN_BITS-1:0]       r_bin;
    logic [NS_BITS-1:0]        r_cnt;

    logic                      r_mag_valid;
    logic [MAG_W-1:0]          r_mag;
    logic [BIN_BITS-1:0]       r_mag_bin;
    logic                      r_frame_done;
    logic                      r_overrun;

    logic signed [ACC_W-1:0]   w_x;
    logic signed [15:0]        w_cos;
    logic signed [15:0]        w_sin;
    logic signed [ACC_W-1:0]   w_s1;
    logic signed [ACC_W-1:0]   w_s2;
    logic signed [ACC_W+15:0]  w_pc;
    logic signed [ACC_W+15:0]  w_ps;
    logic signed [ACC_W-1:0]   w_cterm13;
    logic signed [ACC_W-1:0]   w_cterm14;
    logic signed [ACC_W-1:0]   w_sterm14;
    logic signed [ACC_W-1:0]   w_s0;
    logic [NS_BITS:0]          w_cnt_inc;
    logic                      w_cnt_last;
    logic                      w_bin_last;
    logic signed [ACC_W:0]     w_re_ext;
    logic signed [ACC_W:0]     w_im_ext;
    logic [ACC_W:0]            w_abs_re;
    logic [ACC_W:0]            w_abs_im;
    logic [ACC_W:0]            w_max;
    logic [ACC_W:0]            w_min;
    logic [ACC_W+1:0]          w_m;
    logic [ACC_W+1:0]          w_m_sh;
    logic [MAG_W-1:0]          w_mag_sat;

`ifdef GOERTZEL_DC_REMOVE_EN
    localparam logic [ACC_W-1:0] c_DC_OFFSET = ACC_W'(1) << (D_W - 1);
    assign w_x = $signed({{(ACC_W - D_W){1'b0}}, smp_data} - c_DC_OFFSET);
`else
    assign w_x = $signed({{(ACC_W - D_W){1'b0}}, smp_data});
`endif

    // One shared multiplier pair serves both the recurrence and the final terms
    assign w_cos     = r_cos[r_bin];
    assign w_sin     = r_sin[r_bin];
    assign w_s1      = r_s1[r_bin];
    assign w_s2      = r_s2[r_bin];
    assign w_pc      = $signed({{ACC_W{w_cos[15]}}, w_cos}) * $signed({{16{w_s1[ACC_W-1]}}, w_s1});
    assign w_ps      = $signed({{ACC_W{w_sin[15]}}, w_sin}) * $signed({{16{w_s1[ACC_W-1]}}, w_s1});
    assign w_cterm13 = ACC_W'(w_pc >>> 13);
    assign w_cterm14 = ACC_W'(w_pc >>> 14);
    assign w_sterm14 = ACC_W'(w_ps >>> 14);
    assign w_s0      = r_x + w_cterm13 - w_s2;

    assign w_cnt_inc  = {1'b0, r_cnt} + c_CNT_ONE;
    assign w_cnt_last = (w_cnt_inc == c_FRAME_LEN);
    assign w_bin_last = (r_bin == c_LAST_BIN);

    // One extra bit keeps |most negative| representable
    assign w_re_ext  = {r_re[ACC_W-1], r_re};
    assign w_im_ext  = {r_im[ACC_W-1], r_im};
    assign w_abs_re  = r_re[ACC_W-1] ? (~w_re_ext + c_ABS_ONE) : w_re_ext;
    assign w_abs_im  = r_im[ACC_W-1] ? (~w_im_ext + c_ABS_ONE) : w_im_ext;
    assign w_max     = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
    assign w_min     = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
    assign w_m       = {1'b0, w_max} + {2'b00, w_min[ACC_W:1]};
    assign w_m_sh    = w_m >> MAG_SHIFT;
    assign w_mag_sat = (w_m_sh > c_MAG_MAX) ? {MAG_W{1'b1}} : w_m_sh[MAG_W-1:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:      if (smp_valid) w_next_state = c_ST_UPDATE;
                c_ST_UPDATE:    if (w_bin_last) w_next_state = w_cnt_last ? c_ST_FINAL_MUL : c_ST_IDLE;
                c_ST_FINAL_MUL: w_next_state = c_ST_FINAL_MAG;
                c_ST_FINAL_MAG: w_next_state = w_bin_last ? c_ST_DONE : c_ST_FINAL_MUL;
                c_ST_DONE:      w_next_state = c_ST_IDLE;
                default:        w_next_state = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy = (r_state != c_ST_IDLE);
    end

    // Coefficients stay writable regardless of enable or FSM state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_BINS; i++) begin
                r_cos[i] <= '0;
                r_sin[i] <= '0;
            end
        end else if (coef_we && (int'(coef_addr) < N_BINS)) begin
            r_cos[coef_addr] <= $signed(coef_cos);
            r_sin[coef_addr] <= $signed(coef_sin);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_BINS; i++) begin
                r_s1[i] <= '0;
                r_s2[i] <= '0;
            end
            r_x          <= '0;
            r_re         <= '0;
            r_im         <= '0;
            r_bin        <= '0;
            r_cnt        <= '0;
            r_mag_valid  <= 1'b0;
            r_mag        <= '0;
            r_mag_bin    <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (!enable) begin
            for (int i = 0; i < N_BINS; i++) begin
                r_s1[i] <= '0;
                r_s2[i] <= '0;
            end
            r_bin        <= '0;
            r_cnt        <= '0;
            r_mag_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_mag_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= smp_valid && (r_state != c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    if (smp_valid) begin
                        r_x   <= w_x;
                        r_bin <= '0;
                    end
                end
                c_ST_UPDATE: begin
                    r_s2[r_bin] <= w_s1;
                    r_s1[r_bin] <= w_s0;
                    if (w_bin_last) begin
                        r_bin <= '0;
                        r_cnt <= w_cnt_inc[NS_BITS-1:0];
                    end else begin
                        r_bin <= r_bin + c_BIN_ONE;
                    end
                end
                c_ST_FINAL_MUL: begin
                    r_re <= w_cterm14 - w_s2;
                    r_im <= w_sterm14;
                end
                c_ST_FINAL_MAG: begin
                    r_mag       <= w_mag_sat;
                    r_mag_bin   <= r_bin;
                    r_mag_valid <= 1'b1;
                    r_bin       <= w_bin_last ? '0 : (r_bin + c_BIN_ONE);
                end
                c_ST_DONE: begin
                    r_frame_done <= 1'b1;
                    r_cnt        <= '0;
                    for (int i = 0; i < N_BINS; i++) begin
                        r_s1[i] <= '0;
                        r_s2[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mag_valid  = r_mag_valid;
    assign mag        = r_mag;
    assign mag_bin    = r_mag_bin;
    assign frame_done = r_frame_done;
    assign busy       = w_busy;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/dsp_goertzel_multibin.md
# dsp_goertzel_multibin

Parametrised multi-bin Goertzel engine that replaces the single-run `dsp_goertzel_manager`.
- Accepts one ADC sample per strobe and updates N_BINS Goertzel recurrences time-multiplexed, one bin per clock.
- Holds the per-bin trig coefficients in an internal register file, so no per-run coefficient request handshake is needed.
- After NUM_SAMPLES samples, emits one magnitude per bin as a bin-tagged stream, then starts the next frame.
- Sits between the ADC capture front end and the magnitude detect / threshold logic.

## Interface
Parameters:
- D_W, 8: ADC sample width (unsigned offset binary).
- N_BINS, 4: number of frequency bins; maximum 2^BIN_BITS.
- BIN_BITS, 2: bin index width.
- NUM_SAMPLES, 512: samples per frame.
- NS_BITS, 9: sample counter width.
- ACC_W, 32: signed Goertzel state width.
- MAG_W, 16: output magnitude width.
- MAG_SHIFT, 8: right shift applied to the magnitude before saturation.

Ports:
- sys_clk  in  1  system clock (24 MHz).
- sys_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  low: clears all bin states and the sample count, returns to IDLE, and ignores strobes.
- smp_valid  in  1  one-cycle sample strobe.
- smp_data  in  D_W  sample, captured when smp_valid is high.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  BIN_BITS  bin being written.
- coef_cos  in  16  cos(w), signed Q2.14.
- coef_sin  in  16  sin(w), signed Q2.14.
- mag_valid  out  1  one-cycle pulse per bin result.
- mag  out  MAG_W  magnitude, valid while mag_valid is high.
- mag_bin  out  BIN_BITS  bin index of mag.
- frame_done  out  1  one-cycle pulse after the last bin result.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  one-cycle pulse when a strobe is dropped.

## Operation
- FSM states: IDLE, UPDATE, FINAL_MUL, FINAL_MAG, DONE.
- IDLE:
  - On smp_valid with enable high: latch x, set bin index = 0, go to UPDATE.
  - x = smp_data − 2^(D_W−1) with the macro in Configuration; otherwise x = smp_data zero-extended.
- UPDATE, one cycle per bin b:
  - s0 = x + ((cos_b·s1_b) >>> 13) − s2_b.
  - Then s2_b ← s1_b and s1_b ← s0.
  - All arithmetic is signed, ACC_W-wide, and wraps (no saturation).
  - After bin N_BINS−1, increment the sample count.
  - If the count reaches NUM_SAMPLES: go to FINAL_MUL with b = 0. Otherwise go to IDLE.
- FINAL_MUL, per bin b, registers:
  - re = ((cos_b·s1_b) >>> 14) − s2_b.
  - im = (sin_b·s1_b) >>> 14.
- FINAL_MAG, per bin b:
  - m = max(|re|,|im|) + (min(|re|,|im|) >> 1).
  - mag = sat(m >> MAG_SHIFT, 2^MAG_W − 1).
  - Pulse mag_valid with mag_bin = b.
  - Next state: FINAL_MUL for b+1, or DONE after the last bin.
- DONE:
  - Pulse frame_done.
  - Clear all s1/s2 and the sample count.
  - Go to IDLE.
- Coefficient writes:
  - Accepted in any state, including while enable is low.
  - A write takes effect on the next cycle that uses that bin.
  - coef_addr ≥ N_BINS is ignored.
- A smp_valid arriving in any state other than IDLE is dropped, pulses overrun, and does not advance the sample count.

## Timing
- Reset values:
  - mag_valid, mag, mag_bin, frame_done, busy, overrun all 0.
  - All bin states 0; coefficient registers 0; state IDLE.
- Sample cost: N_BINS cycles in UPDATE. Minimum strobe spacing is N_BINS+1 cycles.
- After the frame's last strobe:
  - First mag_valid is N_BINS+2 cycles later.
  - Subsequent bins follow every 2 cycles.
  - frame_done comes 1 cycle after the last mag_valid.
  - Last strobe to frame_done totals 3·N_BINS+1 cycles.
- enable low has priority over smp_valid in the same cycle. Its clear takes effect on the next clock edge.
- sys_rst_n asserted mid-frame or mid-output clears immediately, and no further mag_valid is emitted.

## Configuration
- GOERTZEL_DC_REMOVE_EN defined: samples are treated as offset binary, x = smp_data − 2^(D_W−1).
- GOERTZEL_DC_REMOVE_EN undefined: x = smp_data zero-extended; the DC term is left to the caller.

## Test plan
All scenarios use NUM_SAMPLES=8, MAG_SHIFT=0, and GOERTZEL_DC_REMOVE_EN defined unless noted.
- Reset: assert sys_rst_n=0 → every output 0 and busy=0. Release, then strobe one sample → busy=1 for exactly N_BINS cycles.
- DC bin: bin0 cos=0x4000, sin=0; eight strobes of 0x81 (x=1) → s1=36, s2=28. Expect mag_valid with mag_bin=0 and mag=8, then frame_done one cycle after the bin3 output.
- Zero input: eight strobes of 0x80 on all bins with nonzero coefficients → four mag_valid pulses, all with mag=0.
- Overrun: strobe, then a second strobe 2 cycles later → overrun pulses once. The second sample is lost, so frame_done needs 8 accepted samples.
- Abort: drop enable after 5 samples, raise it again, then send 8 samples of 0x81 → bin0 mag=8, confirming the cleared state. Repeat with sys_rst_n pulsed during FINAL_MAG → no further mag_valid.
- Macro undefined: eight strobes of 0x01 on the DC bin → mag=8.
